hd_beat_sequencer: RTL
======================

# hd_beat_sequencer

Machine-cycle beat sequencer for the HD-CPU. It generates the one-hot beat signals W[3:1] that the hardwired controller decodes, and owns the ST0 phase flag. It also applies the controller's SHORT/LONG/STOP requests at beat boundaries, and handles start (QD) and single-instruction stepping. It sits between the front-panel start logic and the hardwired controller; the controller's SST0/SHORT/LONG/STOP outputs feed back into this block.

## Interface
- No parameters.
- T3  in  1  clock; one rising edge per beat.
- CLR  in  1  synchronous reset, active-high.
- QD  in  1  start button, level; rising edge detected internally.
- STEP  in  1  1 = halt after every completed instruction cycle.
- SHORT  in  1  from controller: current cycle ends after W1.
- LONG  in  1  from controller: cycle extends to W3.
- STOP  in  1  from controller: halt after the current beat.
- SST0  in  1  from controller: set ST0 at the end of the current beat.
- W  out  3  one-hot beat, W[1]..W[3]; 3'b000 while halted.
- ST0  out  1  phase flag.
- RUN  out  1  1 while a beat is active (W != 0).
- CYC_CNT  out  16  completed instruction cycles, wrapping.

## Operation
- States: HALT, B1, B2, B3. W = {B3, B2, B1}. RUN = !HALT.
- Internal regs: QD_d (QD delayed one edge) and RESUME (beat to enter on restart; encodes B1/B2/B3).
- Start: qd_rise = QD & !QD_d.
  - In HALT with qd_rise, go to RESUME.
  - qd_rise outside HALT is ignored.
- Next-beat rule, evaluated at each edge:
  - B1: SHORT=1 → cycle end, next B1. Otherwise next B2. LONG is ignored in B1.
  - B2: LONG=1 → next B3. Otherwise cycle end, next B1.
  - B3: always cycle end, next B1. LONG is ignored.
- Halt rule:
  - If STOP=1, or (cycle end and STEP=1), go to HALT.
  - RESUME takes the beat the next-beat rule selected.
  - Otherwise go directly to that beat.
- Cycle end increments CYC_CNT by 1, modulo 2^16. This still happens when the same edge enters HALT.
- ST0 is set to 1 at an edge where SST0=1 and state != HALT. It holds otherwise and clears only on CLR. SST0 is ignored in HALT.
- Priority at an edge: CLR > halt rule > next-beat rule.

## Timing
- Reset values after the CLR edge: state HALT, RESUME=B1, W=000, RUN=0, ST0=0, CYC_CNT=0, QD_d=0.
- CLR asserted mid-beat, on any edge, overrides all other inputs and forces the reset values at that edge.
- Start latency:
  - QD is sampled high at edge k with QD_d=0 → W = RESUME beat after edge k.
  - QD held high does not restart after a later halt; it must fall and rise again.
- All outputs are registered, changing only on the rising edge of T3. There is no combinational path from any input to an output.
- SHORT, LONG, STOP and SST0 are sampled at the edge that ends the beat in which they are asserted. The controller derives them combinationally from W.
- Each beat lasts exactly one T3 cycle while running.
- An instruction cycle lasts:
  - 1 cycle with SHORT in B1;
  - 2 cycles for the normal case;
  - 3 cycles with LONG in B2.
- With STOP asserted in beat Bn, Bn completes, then HALT. After qd_rise, execution continues at the beat that would have followed Bn. No beat is skipped or repeated.

## Test plan
- Reset/start: CLR=1 for one edge, then QD 0→1 → W=000 and CYC_CNT=0 until the edge after the rise. Then W=001, and a normal run alternates 001,010 with CYC_CNT incrementing every 2 edges.
- Beat length control:
  - SHORT=1 held in B1 → W stays 001 every cycle, CYC_CNT +1 per edge.
  - LONG=1 in B2 → W sequence 001,010,100,001, CYC_CNT +1 after the 100 beat.
- STOP mid-cycle:
  - STOP=1 during B2 with LONG=1 → W=000, RUN=0.
  - Next QD rise → W=100, then 001.
  - CYC_CNT increments only after the B3 beat.
- STEP mode: STEP=1, QD pulses → each pulse yields exactly one cycle (001,010 then 000), CYC_CNT +1 per pulse. QD held high yields a single cycle only.
- ST0 and SST0:
  - SST0=1 in B1 → ST0=1 from the next edge, held across HALT and restart.
  - SST0 forced high while halted → ST0 stays 0.
  - CLR → ST0=0.
- Wrap and reset mid-run:
  - Preload 65535 cycles by run, then one more cycle → CYC_CNT=0x0000.
  - CLR during B2 → W=000, CYC_CNT=0, RESUME=B1 at that edge.

Source files
------------

// File: rtl/hd_beat_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hd_beat_sequencer_if
// Description : Signal bundle between the hardwired controller / front panel
//               and the beat sequencer.
//               Controller-to-sequencer: QD, STEP, SHORT, LONG, STOP, SST0.
//               Sequencer-to-controller: W[3:1], ST0, RUN, CYC_CNT[15:0].
//               The master modport belongs to the controller side.
//               The slave modport belongs to the sequencer.
// Revision    : 1.0  initial release
// ============================================================================
interface hd_beat_sequencer_if;
    logic        QD;
    logic        STEP;
    logic        SHORT;
    logic        LONG;
    logic        STOP;
    logic        SST0;
    logic [3:1]  W;
    logic        ST0;
    logic        RUN;
    logic [15:0] CYC_CNT;

    modport master (
        output QD, STEP, SHORT, LONG, STOP, SST0,
        input  W, ST0, RUN, CYC_CNT
    );

    modport slave (
        input  QD, STEP, SHORT, LONG, STOP, SST0,
        output W, ST0, RUN, CYC_CNT
    );
endinterface
`default_nettype wire

// File: rtl/hd_beat_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hd_beat_sequencer
// Description : Machine-cycle beat sequencer for the HD-CPU. It produces the
//               one-hot beats W[3:1] and owns the ST0 phase flag. It applies
//               the controller's SHORT/LONG/STOP requests at beat boundaries.
//               It also handles start (QD rising edge) and single-cycle
//               stepping.
// Ports       : T3   - clock, one rising edge per beat
//               CLR  - synchronous active-high reset
//               bus  - hd_beat_sequencer_if.slave
//                      inputs : QD, STEP, SHORT, LONG, STOP, SST0
//                      outputs: W, ST0, RUN, CYC_CNT
// Revision    : 1.0  initial release
// ============================================================================
module hd_beat_sequencer (
    input  wire logic              T3,
    input  wire logic              CLR,
    hd_beat_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2,
        S_B3   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      r_resume;
    logic        r_qd_d;
    logic        r_st0;
    logic [15:0] r_cyc_cnt;

    state_t      w_state_nxt;
    state_t      w_resume_nxt;
    state_t      w_beat_nxt;
    logic        w_cyc_end;
    logic        w_qd_rise;

    // The next-beat rule is worked out first.
    // The halt rule then decides whether that beat is entered now.
    // If the sequencer halts instead, the beat is parked in r_resume.
    always_comb begin
        w_qd_rise    = bus.QD & ~r_qd_d;
        w_cyc_end    = 1'b0;
        w_beat_nxt   = S_B1;
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume;

        case (r_state)
            S_HALT: begin
                if (w_qd_rise) begin
                    w_state_nxt = r_resume;
                end
            end
            S_B1: begin
                if (bus.SHORT) begin
                    w_cyc_end  = 1'b1;
                    w_beat_nxt = S_B1;
                end else begin
                    w_beat_nxt = S_B2;
                end
            end
            S_B2: begin
                if (bus.LONG) begin
                    w_beat_nxt = S_B3;
                end else begin
                    w_cyc_end  = 1'b1;
                    w_beat_nxt = S_B1;
                end
            end
            default: begin
                // S_B3: always closes the cycle
                w_cyc_end  = 1'b1;
                w_beat_nxt = S_B1;
            end
        endcase

        if (r_state != S_HALT) begin
            if (bus.STOP || (w_cyc_end && bus.STEP)) begin
                w_state_nxt  = S_HALT;
                w_resume_nxt = w_beat_nxt;
            end else begin
                w_state_nxt  = w_beat_nxt;
            end
        end
    end

    always_ff @(posedge T3) begin
        if (CLR) begin
            r_state   <= S_HALT;
            r_resume  <= S_B1;
            r_qd_d    <= 1'b0;
            r_st0     <= 1'b0;
            r_cyc_cnt <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
            r_qd_d   <= bus.QD;
            // A cycle that ends on the same edge that halts still counts.
            if (w_cyc_end) begin
                r_cyc_cnt <= r_cyc_cnt + 16'd1;
            end
            if (bus.SST0 && (r_state != S_HALT)) begin
                r_st0 <= 1'b1;
            end
        end
    end

    // The outputs are decoded from registers only, so no input reaches them
    // combinationally.
    assign bus.W       = {r_state == S_B3, r_state == S_B2, r_state == S_B1};
    assign bus.RUN     = (r_state != S_HALT);
    assign bus.ST0     = r_st0;
    assign bus.CYC_CNT = r_cyc_cnt;

endmodule
`default_nettype wire
